// File: rtl/arbitrated_multiplexer_pkg.sv
// Shared types and helpers for the arbitrated multiplexer.
package mux_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_e;

  // Successor of idx, wrapping to 0 after size-1.
  function automatic int unsigned next_index(input int unsigned idx, input int unsigned size);
    return (idx + 1 >= size) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arbitrated_multiplexer_rr_arbiter.sv
// Combinational arbiter: rotating search from ptr, or fixed lowest-index-first.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned SIZE = 2,
  parameter int unsigned IW   = $clog2(SIZE)
) (
  input  logic [SIZE-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            rotate,
  output logic [SIZE-1:0] grant,
  output logic [IW-1:0]   index
);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    idx   = rotate ? ptr : '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        index      = idx;
      end
      idx = IW'(next_index(32'(idx), SIZE));
    end
  end

endmodule

// File: rtl/arbitrated_multiplexer.sv
// Valid/ready N:1 multiplexer with internal arbitration, optional packet lock,
// and a one-entry registered output stage.
module arbitrated_multiplexer
  import mux_pkg::*;
#(
  parameter int unsigned SIZE        = 2,
  parameter type         T           = logic,
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter bit          PACKET      = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [SIZE-1:0]         in_valid,
  input  T     [SIZE-1:0]         in_data,
  input  logic [SIZE-1:0]         in_last,
  output logic [SIZE-1:0]         in_ready,
  output logic                    out_valid,
  output T                        out_data,
  output logic                    out_last,
  output logic [$clog2(SIZE)-1:0] out_channel,
  input  logic                    out_ready
);

  localparam int unsigned IW = $clog2(SIZE);

  arb_state_e      state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   lock_ch;
  logic [IW-1:0]   arb_index;
  logic [IW-1:0]   gidx;
  logic [SIZE-1:0] arb_grant;
  logic [SIZE-1:0] grant;
  logic            load;
  logic            locked;
  logic            accept;
  logic            acc_last;

  rr_arbiter #(.SIZE(SIZE), .IW(IW)) u_arb (
    .req    (in_valid),
    .ptr    (ptr),
    .rotate (ROUND_ROBIN),
    .grant  (arb_grant),
    .index  (arb_index)
  );

  assign load   = ~out_valid | out_ready;
  assign locked = PACKET && (state == LOCKED);

  // While locked the grant sits on lock_ch even if that channel is idle.
  always_comb begin
    grant = arb_grant;
    gidx  = arb_index;
    if (locked) begin
      grant = '0;
      grant[lock_ch] = 1'b1;
      gidx  = lock_ch;
    end
  end

  assign in_ready = grant & {SIZE{load}};
  assign accept   = |(in_valid & in_ready);
  assign acc_last = PACKET ? in_last[gidx] : 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_channel <= '0;
      ptr         <= '0;
      lock_ch     <= '0;
      state       <= IDLE;
    end else begin
      if (load) out_valid <= accept;
      if (accept) begin
        out_data    <= in_data[gidx];
        out_last    <= acc_last;
        out_channel <= gidx;
        // With PACKET=0 every beat is a last beat, so the FSM never leaves IDLE.
        if (acc_last) begin
          ptr   <= IW'(next_index(32'(gidx), SIZE));
          state <= IDLE;
        end else begin
          lock_ch <= gidx;
          state   <= LOCKED;
        end
      end
    end
  end

endmodule

// File: tb/tb_arbitrated_multiplexer.sv
// Bench for arbitrated_multiplexer: four configurations checked against a
// behavioural model every cycle, plus directed literal expectations.
module tb_arbitrated_multiplexer;

  localparam int SZ [4] = '{4, 4, 2, 3};
  localparam bit RR [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam bit PK [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] v [4];
  logic [3:0] l [4];
  logic [7:0] d [4][4];
  logic       ordy [4];

  logic [3:0] r0, r1;
  logic [1:0] r2;
  logic [2:0] r3;
  logic       ov [4];
  logic [7:0] od [4];
  logic       ol [4];
  logic [1:0] oc0, oc1, oc3;
  logic       oc2;

  arbitrated_multiplexer #(.SIZE(4), .T(logic [7:0]), .ROUND_ROBIN(1'b1), .PACKET(1'b0)) u_rr4 (
    .clk(clk), .reset_n(reset_n), .in_valid(v[0]), .in_data({d[0][3], d[0][2], d[0][1], d[0][0]}),
    .in_last(l[0]), .in_ready(r0), .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]),
    .out_channel(oc0), .out_ready(ordy[0]));

  arbitrated_multiplexer #(.SIZE(4), .T(logic [7:0]), .ROUND_ROBIN(1'b0), .PACKET(1'b0)) u_fp4 (
    .clk(clk), .reset_n(reset_n), .in_valid(v[1]), .in_data({d[1][3], d[1][2], d[1][1], d[1][0]}),
    .in_last(l[1]), .in_ready(r1), .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]),
    .out_channel(oc1), .out_ready(ordy[1]));

  arbitrated_multiplexer #(.SIZE(2), .T(logic [7:0]), .ROUND_ROBIN(1'b1), .PACKET(1'b1)) u_pk2 (
    .clk(clk), .reset_n(reset_n), .in_valid(v[2][1:0]), .in_data({d[2][1], d[2][0]}),
    .in_last(l[2][1:0]), .in_ready(r2), .out_valid(ov[2]), .out_data(od[2]), .out_last(ol[2]),
    .out_channel(oc2), .out_ready(ordy[2]));

  arbitrated_multiplexer #(.SIZE(3), .T(logic [7:0]), .ROUND_ROBIN(1'b1), .PACKET(1'b0)) u_rr3 (
    .clk(clk), .reset_n(reset_n), .in_valid(v[3][2:0]), .in_data({d[3][2], d[3][1], d[3][0]}),
    .in_last(l[3][2:0]), .in_ready(r3), .out_valid(ov[3]), .out_data(od[3]), .out_last(ol[3]),
    .out_channel(oc3), .out_ready(ordy[3]));

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int k, input int act, input int exp);
    checks++;
    if (act !== exp) $display("FAIL %s dut%0d actual=%0d required=%0d t=%0t", name, k, act, exp, $time);
    else passes++;
  endtask

  // Model state: what the output register holds, where the search starts, lock.
  typedef struct {
    bit         ov;
    logic [7:0] od;
    bit         ol;
    int         oc;
    int         ptr;
    bit         locked;
    int         lch;
  } ms_t;
  ms_t m [4];

  function automatic int winner(input int k);
    int c;
    if (m[k].locked) return m[k].lch;
    for (int i = 0; i < SZ[k]; i++) begin
      c = ((RR[k] ? m[k].ptr : 0) + i) % SZ[k];
      if (v[k][c] === 1'b1) return c;
    end
    return -1;
  endfunction

  function automatic int exp_ready(input int k);
    int w;
    if (m[k].ov && ordy[k] !== 1'b1) return 0;
    w = winner(k);
    return (w < 0) ? 0 : (1 << w);
  endfunction

  function automatic int act_ready(input int k);
    case (k)
      0: return int'(r0);
      1: return int'(r1);
      2: return int'(r2);
      default: return int'(r3);
    endcase
  endfunction

  function automatic int act_ch(input int k);
    case (k)
      0: return int'(oc0);
      1: return int'(oc1);
      2: return int'(oc2);
      default: return int'(oc3);
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int k = 0; k < 4; k++) begin : upd
      bit ld;
      bit acc;
      bit lb;
      int w;
      if (!reset_n) begin
        m[k].ov = 1'b0; m[k].od = '0; m[k].ol = 1'b0; m[k].oc = 0;
        m[k].ptr = 0; m[k].locked = 1'b0; m[k].lch = 0;
      end else begin
        ld  = !m[k].ov || (ordy[k] === 1'b1);
        w   = winner(k);
        acc = ld && (w >= 0) && (v[k][w] === 1'b1);
        if (ld) m[k].ov = acc;
        if (acc) begin
          lb = PK[k] ? l[k][w] : 1'b1;
          m[k].od = d[k][w];
          m[k].ol = lb;
          m[k].oc = w;
          if (lb) begin
            m[k].ptr = (w + 1) % SZ[k];
            m[k].locked = 1'b0;
          end else begin
            m[k].locked = 1'b1;
            m[k].lch = w;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      check("in_ready", k, act_ready(k), exp_ready(k));
      check("out_valid", k, int'(ov[k]), int'(m[k].ov));
      check("out_data", k, int'(od[k]), int'(m[k].od));
      check("out_last", k, int'(ol[k]), int'(m[k].ol));
      check("out_channel", k, act_ch(k), m[k].oc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      v[k] = '0; l[k] = '0; ordy[k] = 1'b1;
      for (int i = 0; i < 4; i++) d[k][i] = '0;
    end
    tick();
    tick();
    check("reset_valid", 0, int'(ov[0]), 0);
    check("reset_data", 2, int'(od[2]), 0);
    check("reset_last", 1, int'(ol[1]), 0);
    check("reset_channel", 3, int'(oc3), 0);
    reset_n = 1'b1;

    // Round-robin, all channels valid: 0,1,2,3,0,...
    for (int i = 0; i < 4; i++) d[0][i] = 8'(i);
    v[0] = 4'hF;
    for (int n = 0; n < 8; n++) begin
      tick();
      check("rr4_seq_ch", 0, int'(oc0), n % 4);
      check("rr4_seq_data", 0, int'(od[0]), n % 4);
    end
    v[0] = 4'h0;
    tick();
    check("rr4_drain_valid", 0, int'(ov[0]), 0);
    check("rr4_drain_data_kept", 0, int'(od[0]), 3);

    // Fixed priority with requests 1010: channel 1 always wins.
    v[1] = 4'b1010; d[1][1] = 8'h11; d[1][3] = 8'h33;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("fp_ch", 1, int'(oc1), 1);
      check("fp_ready", 1, int'(r1), 4'b0010);
    end
    v[1] = 4'b1000;
    tick();
    check("fp_ch3_alone", 1, int'(oc1), 3);
    v[1] = 4'b0000;

    // Backpressure: 0xA5 held for three stalled cycles.
    d[0][2] = 8'hA5; v[0] = 4'b0100;
    tick();
    check("bp_first", 0, int'(od[0]), 8'hA5);
    ordy[0] = 1'b0; d[0][2] = 8'h5A;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("bp_hold_data", 0, int'(od[0]), 8'hA5);
      check("bp_hold_valid", 0, int'(ov[0]), 1);
      check("bp_hold_ready", 0, int'(r0), 0);
    end
    ordy[0] = 1'b1;
    #1;
    check("bp_release_ready", 0, int'(r0), 4'b0100);
    tick();
    check("bp_next", 0, int'(od[0]), 8'h5A);
    v[0] = 4'b0000;

    // Packet mode: ch0 three beats with a two-cycle gap, ch1 valid throughout.
    d[2][1] = 8'h77; l[2] = 4'b0010;
    v[2] = 4'b0011; d[2][0] = 8'h10;
    tick();
    check("pk_b1", 2, int'(oc2), 0);
    d[2][0] = 8'h20;
    tick();
    check("pk_b2", 2, int'(oc2), 0);
    v[2] = 4'b0010;
    for (int n = 0; n < 2; n++) begin
      tick();
      check("pk_gap_ready", 2, int'(r2), 2'b01);
      check("pk_gap_valid", 2, int'(ov[2]), 0);
    end
    v[2] = 4'b0011; d[2][0] = 8'h30; l[2] = 4'b0011;
    tick();
    check("pk_b3_ch", 2, int'(oc2), 0);
    check("pk_b3_last", 2, int'(ol[2]), 1);
    v[2] = 4'b0010; l[2] = 4'b0000;
    tick();
    check("pk_ch1", 2, int'(oc2), 1);
    check("pk_ch1_data", 2, int'(od[2]), 8'h77);

    // Asynchronous reset while holding a beat and locked on ch1.
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_valid", 2, int'(ov[2]), 0);
    check("rst_async_data", 2, int'(od[2]), 0);
    tick();
    reset_n = 1'b1;
    v[2] = 4'b0011; l[2] = 4'b0011; d[2][0] = 8'hC0; d[2][1] = 8'hC1;
    tick();
    check("rst_restart_ch", 2, int'(oc2), 0);
    check("rst_restart_data", 2, int'(od[2]), 8'hC0);
    tick();
    check("rst_next_ch", 2, int'(oc2), 1);
    v[2] = 4'b0000;

    // SIZE=3 round-robin wrap.
    for (int i = 0; i < 3; i++) d[3][i] = 8'(8'h30 + i);
    v[3] = 4'b0111;
    for (int n = 0; n < 7; n++) begin
      tick();
      check("rr3_seq", 3, int'(oc3), n % 3);
    end
    v[3] = 4'b0101;
    tick();
    check("rr3_skip", 3, int'(oc3), 2);
    tick();
    check("rr3_wrap", 3, int'(oc3), 0);
    v[3] = 4'b0000;
    tick();
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
